// File: rtl/cordic_atan2_16bit.sv
// Iterative vectoring-mode CORDIC: signed 16.16 (x, y) -> 16-bit phase and gain-compensated
// magnitude, one micro-rotation per cycle on a start/done/ready handshake.
module cordic_atan2_16bit #(
    parameter int unsigned ITER    = 16,
    parameter logic [31:0] K_SCALE = 32'h00009B75
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic [15:0] angle,
    output logic [31:0] magnitude,
    output logic        done,
    output logic        ready
);

    typedef enum logic [1:0] {StIdle, StIter, StScale, StDone} state_e;

    // atan(2^-i) in units of 2*pi/65536
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    localparam logic [3:0] LastIter = 4'(ITER - 1);

    state_e             state_q, state_d;
    logic signed [34:0] x_q, x_d, y_q, y_d;
    logic [15:0]        z_q, z_d;
    logic [3:0]         iter_q, iter_d;
    logic               zero_q, zero_d;
    logic [15:0]        angle_d;
    logic [31:0]        mag_d;
    logic               done_d, ready_d;

    logic signed [34:0] x_ext, y_ext, x_sh, y_sh;
    logic [66:0]        prod;
    logic [50:0]        mag_wide;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        angle_d = angle;
        mag_d   = magnitude;
        done_d  = done;
        ready_d = ready;

        x_ext    = {{3{x_in[31]}}, x_in};
        y_ext    = {{3{y_in[31]}}, y_in};
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        // x is non-negative after the iterations, so the unsigned product is exact
        prod     = 67'($unsigned(x_q)) * 67'(K_SCALE);
        mag_wide = 51'(prod >> 16);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Fold the left half-plane onto the right by rotating through pi
                    if (x_in[31]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = 16'h8000;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = 16'h0000;
                    end
                    zero_d  = (x_in == 32'd0) && (y_in == 32'd0);
                    iter_d  = 4'd0;
                    ready_d = 1'b0;
                    state_d = StIter;
                end
            end
            StIter: begin
                if (!y_q[34]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + ATAN[iter_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - ATAN[iter_q];
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == LastIter) begin
                    state_d = StScale;
                end
            end
            StScale: begin
                if (zero_q) begin
                    angle_d = 16'd0;
                    mag_d   = 32'd0;
                end else begin
                    angle_d = z_q;
                    mag_d   = (|mag_wide[50:32]) ? 32'hFFFF_FFFF : mag_wide[31:0];
                end
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            iter_q    <= '0;
            zero_q    <= 1'b0;
            angle     <= '0;
            magnitude <= '0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            iter_q    <= iter_d;
            zero_q    <= zero_d;
            angle     <= angle_d;
            magnitude <= mag_d;
            done      <= done_d;
            ready     <= ready_d;
        end
    end

endmodule

// File: tb/tb_cordic_atan2_16bit.sv
// Self-checking bench for cordic_atan2_16bit: real-valued atan2/hypot reference, cycle-exact
// handshake checks, reset abort, boundary vectors and a randomized sweep.
module tb_cordic_atan2_16bit;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x_in, y_in;
    logic [15:0] angle;
    logic [31:0] magnitude;
    logic        done, ready;

    int checks = 0;
    int fails  = 0;

    real qa[$];
    real qm[$];
    bit  qz[$];
    real held_a, held_m;
    bit  held_z;
    bit  have_held = 1'b0;
    bit  chk_en    = 1'b0;

    cordic_atan2_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle     (angle),
        .magnitude (magnitude),
        .done      (done),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [31:0] xv, input logic [31:0] yv,
                         output real a, output real m, output bit z);
        real xr, yr;
        xr = real'($signed(xv));
        yr = real'($signed(yv));
        z  = (xv == 32'd0) && (yv == 32'd0);
        a  = $atan2(yr, xr);
        if (a < 0.0) a = a + 2.0 * PI;
        a  = a * 65536.0 / (2.0 * PI);
        m  = $sqrt(xr * xr + yr * yr);
        if (m > 4294967295.0) m = 4294967295.0;
    endtask

    function automatic bit ang_ok(input logic [15:0] got, input real want);
        longint     ri;
        logic [15:0] r16, d;
        ri  = longint'(want);
        r16 = ri[15:0];
        d   = got - r16;
        return ($signed(d) >= -16'sd4) && ($signed(d) <= 16'sd4);
    endfunction

    task automatic check_out(input string name, input real ea, input real em, input bit ez);
        real mr, tol;
        bit  ok;
        checks++;
        mr  = real'(longint'({32'd0, magnitude}));
        tol = em / 4096.0;
        if (tol < 32.0) tol = 32.0;
        if (ez) ok = (angle == 16'd0) && (magnitude == 32'd0);
        else    ok = ang_ok(angle, ea) && ((mr - em) <= tol) && ((em - mr) <= tol);
        if (!ok) begin
            fails++;
            $display("FAIL %s: got angle=%0d mag=%0d, want angle~%0.1f mag~%0.1f zero=%0b",
                     name, angle, magnitude, ea, em, ez);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    task automatic chk_lit(input string name, input logic [15:0] wa, input longint wm,
                           input longint tol);
        longint mg;
        checks++;
        mg = longint'({32'd0, magnitude});
        if (!ang_ok(angle, real'(wa)) || (mg - wm > tol) || (wm - mg > tol)) begin
            fails++;
            $display("FAIL %s: got angle=%0d mag=%0d, want angle=%0d+-4 mag=%0d+-%0d",
                     name, angle, magnitude, wa, wm, tol);
        end
    endtask

    // Compare process: every cycle, a done pulse must match the oldest expectation and
    // otherwise the outputs must still hold the last result.
    initial begin
        real ea, em;
        bit  ez;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                if (done === 1'b1) begin
                    if (qa.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: got done=1, want no result pending");
                    end else begin
                        ea = qa.pop_front();
                        em = qm.pop_front();
                        ez = qz.pop_front();
                        check_out("result", ea, em, ez);
                        held_a = ea;
                        held_m = em;
                        held_z = ez;
                        have_held = 1'b1;
                    end
                end else if (have_held) begin
                    check_out("hold", held_a, held_m, held_z);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_bit("ready_wait", ready, 1'b1);
    endtask

    // Issue one operation at edge T and check the handshake cycle by cycle up to T+18.
    task automatic do_op(input logic [31:0] xv, input logic [31:0] yv, input bit ign);
        real a, m;
        bit  z;
        wait_ready();
        model(xv, yv, a, m, z);
        qa.push_back(a);
        qm.push_back(m);
        qz.push_back(z);
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_in  = $urandom;
        y_in  = $urandom;
        chk_bit("ready_low_after_start", ready, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            if (ign && k == 5) begin
                start = 1'b1;
                x_in  = $urandom;
                y_in  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k <= 16) begin
                chk_bit("busy_done", done, 1'b0);
                chk_bit("busy_ready", ready, 1'b0);
            end else if (k == 17) begin
                chk_bit("done_pulse", done, 1'b1);
                chk_bit("ready_at_done", ready, 1'b0);
            end else begin
                chk_bit("done_cleared", done, 1'b0);
                chk_bit("ready_back", ready, 1'b1);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xv, yv;
        int          s;
        real         xr, yr;

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_ready", ready, 1'b1);
        chk_lit("rst_outputs", 16'd0, 0, 0);
        rst    = 1'b0;
        held_a = 0.0;
        held_m = 0.0;
        held_z = 1'b1;
        have_held = 1'b1;
        chk_en = 1'b1;

        do_op(32'h0001_0000, 32'h0000_0000, 1'b0);
        chk_lit("axis_pos_x", 16'd0, 65536, 16);
        do_op(32'h0000_0000, 32'h0001_0000, 1'b1);
        chk_lit("axis_pos_y_ignored_start", 16'd16384, 65536, 16);
        do_op(32'hFFFF_0000, 32'h0000_0000, 1'b0);
        chk_lit("axis_neg_x", 16'd32768, 65536, 16);
        do_op(32'h0000_0000, 32'hFFFF_0000, 1'b0);
        chk_lit("axis_neg_y", 16'd49152, 65536, 16);
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        chk_lit("diag_q1", 16'd8192, 92682, 32);
        do_op(32'hFFFF_0000, 32'hFFFF_0000, 1'b0);
        chk_lit("diag_q3", 16'd40960, 92682, 32);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0);
        chk_lit("zero_vector", 16'd0, 0, 0);
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        chk_lit("full_scale_diag", 16'd8192, 64'd3037000499, 64'd3037000499 >> 12);
        do_op(32'h8000_0000, 32'h0000_0000, 1'b0);
        chk_lit("most_negative_x", 16'd32768, 64'd2147483648, 64'd2147483648 >> 12);

        // Reset at edge T+8 aborts the operation in flight
        wait_ready();
        x_in  = 32'h0003_0000;
        y_in  = 32'h0002_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst    = 1'b1;
        held_a = 0.0;
        held_m = 0.0;
        held_z = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bit("abort_ready", ready, 1'b1);
        chk_bit("abort_done", done, 1'b0);
        chk_lit("abort_outputs", 16'd0, 0, 0);
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        chk_lit("after_abort", 16'd8192, 92682, 32);

        for (int n = 0; n < 1000; n++) begin
            do begin
                s  = $urandom_range(0, 14);
                xv = $unsigned($signed($urandom) >>> s);
                yv = $unsigned($signed($urandom) >>> s);
                xr = real'($signed(xv));
                yr = real'($signed(yv));
            end while (xr * xr + yr * yr < 1099511627776.0);
            do_op(xv, yv, $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            fails++;
            $display("FAIL pending_results: got %0d outstanding, want 0", qa.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/cordic_atan2_16bit.md
Name: cordic_atan2_16bit

Overview:
- Iterative CORDIC in vectoring mode; the inverse of the team's rotation-mode sine/cosine block.
- Converts a Cartesian vector (x, y) in signed 16.16 fixed point into a 16-bit phase angle (0-65535 maps to 0-2π) and a gain-compensated magnitude.
- Sits beside the sin/cos block on the same start/done/ready handshake, so phase/magnitude recovery closes the loop with angle-to-vector generation.

Parameters:
- ITER, 16, number of CORDIC micro-rotations (fixed at 16; the atan table has 16 entries).
- K_SCALE, 32'h00009B75, gain compensation 0.607253 in 0.16 fixed point (39797).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- x_in  input  32  signed 16.16 x component.
- y_in  input  32  signed 16.16 y component.
- angle  output  16  atan2(y,x); 0-65535 maps to 0-2π, wraps modulo 2^16.
- magnitude  output  32  unsigned 16.16 sqrt(x²+y²), gain-compensated.
- done  output  1  one-cycle pulse when angle/magnitude are updated.
- ready  output  1  high when idle and able to accept start.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - angle=0, magnitude=0, done=0, ready=1, state=IDLE.
  - Internal x/y/z/iteration cleared.
  - Reset in any state, including mid-computation, aborts the operation; no done pulse follows.
- States: IDLE -> ITER -> SCALE -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - At an edge with start=1, capture the inputs, go to ITER, ready<=0.
- Capture and pre-rotation (35-bit signed internal x, y so negation and CORDIC gain ≈2.33 never overflow):
  - x_in ≥ 0: x=x_in, y=y_in, z=0.
  - x_in < 0: x=-x_in, y=-y_in, z=16'h8000 (π).
  - zero_flag<=1 when x_in=0 and y_in=0.
- ITER, iteration i = 0..15, one micro-rotation per cycle:
  - y ≥ 0: x<=x+(y>>>i), y<=y-(x>>>i), z<=z+atan[i].
  - y < 0: x<=x-(y>>>i), y<=y+(x>>>i), z<=z-atan[i].
  - All shifts are arithmetic. z is 16-bit and wraps modulo 2^16, so negative results map to the 3π/2-2π range.
  - After i=15, go to SCALE.
- atan[i] values (angle units): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- SCALE (one cycle):
  - prod = x_final(35b, non-negative) × K_SCALE; mag = prod >> 16.
  - If mag > 32'hFFFFFFFF, saturate to 32'hFFFFFFFF.
  - angle<=z; magnitude<=mag; done<=1.
  - If zero_flag=1: angle<=0, magnitude<=0.
- DONE (one cycle): done<=0, ready<=1, go to IDLE.
- Latency:
  - Start accepted at edge T. Micro-rotations at edges T+1..T+16.
  - Outputs and done=1 registered at edge T+17; done=0 and ready=1 at edge T+18.
  - Next start is accepted at edge T+19 at the earliest. Throughput is one result per 19 cycles.
- Handshakes and holding:
  - start while ready=0 is ignored entirely; no queuing.
  - x_in/y_in need only be valid at the accepting edge.
  - angle/magnitude hold their last values until the next SCALE state or reset.
- Accuracy:
  - |angle error| ≤ 4 LSB for inputs with magnitude ≥ 2^-4.
  - Magnitude relative error ≤ 2^-12.
- Boundaries:
  - x=0, y>0 gives ≈16384; x=0, y<0 gives ≈49152.
  - x<0, y=0 gives ≈32768.
  - x_in = 32'h80000000 (most negative) negates correctly in 35-bit width.

Test Plan:
- Axes: (0x00010000,0) -> angle 0±4 (result near 65535 accepted as wrap), magnitude 0x10000±16; (0,0x00010000) -> 16384±4; (0xFFFF0000,0) -> 32768±4; (0,0xFFFF0000) -> 49152±4.
- Diagonal: (0x00010000,0x00010000) -> angle 8192±4, magnitude 92682±32. (0xFFFF0000,0xFFFF0000) -> 40960±4.
- Timing: start pulse at edge T -> ready=0 from T; done high exactly one cycle after edge T+17; ready=1 after T+18. A start asserted at T+5 is ignored and outputs are unchanged by it.
- Zero vector (0,0) -> angle 0, magnitude 0, done pulses at normal latency.
- Full-scale: (0x7FFFFFFF,0x7FFFFFFF) -> angle 8192±4, magnitude ≈ 0xB504F333 within 2^-12, no wrap. (0x80000000,0) -> angle 32768±4, magnitude ≈ 0x80000000.
- Reset at edge T+8 mid-ITER -> ready=1, done stays 0, outputs 0. A new start at the next edge completes correctly.
- Random sweep: 1000 random vectors compared against a reference atan2/hypot model within the stated tolerances.
